icache_sa: RTL

Parametrised N-way set-associative instruction cache sitting between the CPU fetch stage and the read bus, replacing the fixed single-configuration ICache. It serves hits from on-chip line storage in two cycles and refills whole lines over the existing burst read interface on a miss. It adds configurable geometry, selectable replacement policy, a whole-cache invalidate (fence.i) handshake and saturating hit/miss counters.

---
 rtl/icache_pkg.sv | 34 +++
 rtl/icache_victim_sel.sv | 53 +++++
 rtl/icache_sa.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared definitions for the set-associative instruction cache: FSM states,
// replacement LFSR constants and address-field width helpers.
package icache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_MISS_WAIT,
        ST_REFILL,
        ST_INVAL
    } state_t;

    localparam logic [7:0] LFSR_SEED = 8'hE1;
    // Fibonacci taps 8,6,5,4 -> register bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [3:0] REN_LINE  = 4'hF;

    function automatic int unsigned off_bits(input int unsigned line_words);
        return $clog2(line_words) + 2;
    endfunction

    function automatic int unsigned idx_bits(input int unsigned sets);
        return $clog2(sets);
    endfunction

    function automatic int unsigned tag_bits(input int unsigned sets, input int unsigned line_words);
        return 32 - idx_bits(sets) - off_bits(line_words);
    endfunction

    function automatic int unsigned way_bits(input int unsigned ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/icache_victim_sel.sv
// Victim way selection: lowest invalid way first, otherwise LFSR or per-set
// round-robin depending on REPL_MODE.
module icache_victim_sel
    import icache_pkg::*;
#(
    parameter  int unsigned WAYS      = 4,
    parameter  int unsigned SETS      = 16,
    parameter  int unsigned REPL_MODE = 0,
    localparam int unsigned WW        = way_bits(WAYS),
    localparam int unsigned IW        = idx_bits(SETS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [WAYS-1:0] valid_set,
    input  logic [IW-1:0]   set_idx,
    input  logic            evict,
    output logic [WW-1:0]   victim
);

    logic [7:0]    lfsr;
    logic [WW-1:0] rr_ptr [SETS];
    logic [WW-1:0] first_free;
    logic          any_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
            for (int unsigned s = 0; s < SETS; s++) rr_ptr[s] <= '0;
        end else begin
            lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
            if (evict) rr_ptr[set_idx] <= WW'((32'(rr_ptr[set_idx]) + 1) % WAYS);
        end
    end

    // Scan downwards so the lowest-index invalid way wins.
    always_comb begin
        any_free   = 1'b0;
        first_free = '0;
        for (int unsigned w = WAYS; w > 0; w--) begin
            if (!valid_set[WW'(w - 1)]) begin
                any_free   = 1'b1;
                first_free = WW'(w - 1);
            end
        end
    end

    always_comb begin
        if (any_free)            victim = first_free;
        else if (REPL_MODE == 1) victim = rr_ptr[set_idx];
        else                     victim = WW'(lfsr) & WW'(WAYS - 1);
    end

endmodule

// File: rtl/icache_sa.sv
// N-way set-associative instruction cache: two-cycle hits, whole-line refill
// over the burst read bus, invalidate-all handshake, saturating counters.
module icache_sa
    import icache_pkg::*;
#(
    parameter int unsigned WAYS       = 4,
    parameter int unsigned SETS       = 16,
    parameter int unsigned LINE_WORDS = 8,
    parameter int unsigned REPL_MODE  = 0
) (
    input  logic                     cpu_clk,
    input  logic                     cpu_rst_n,
    input  logic                     inst_rreq,
    input  logic [31:0]              inst_addr,
    output logic                     inst_valid,
    output logic [31:0]              inst_out,
    input  logic                     inv_req,
    output logic                     inv_done,
    input  logic                     dev_rrdy,
    output logic [3:0]               cpu_ren,
    output logic [31:0]              cpu_raddr,
    input  logic                     dev_rvalid,
    input  logic [LINE_WORDS*32-1:0] dev_rdata,
    output logic [31:0]              hit_cnt,
    output logic [31:0]              miss_cnt
);

    localparam int unsigned OFF = off_bits(LINE_WORDS);
    localparam int unsigned IW  = idx_bits(SETS);
    localparam int unsigned TW  = tag_bits(SETS, LINE_WORDS);
    localparam int unsigned WW  = way_bits(WAYS);
    localparam int unsigned OW  = OFF - 2;

    state_t state_q, state_d;

    logic [31:2]              addr_q;
    logic [TW-1:0]            tag_l;
    logic [IW-1:0]            idx_l;
    logic [OW-1:0]            word_l;
    logic [LINE_WORDS*32-1:0] line_q  [WAYS][SETS];
    logic [TW-1:0]            tag_q   [WAYS][SETS];
    logic [WAYS-1:0]          valid_q [SETS];
    logic [WW-1:0]            victim, victim_q;
    logic                     hit, lookup, fill, evict;
    logic [31:0]              hit_word, refill_word, line_addr;
    logic                     valid_d, done_d;
    logic [31:0]              out_d, raddr_d;
    logic [3:0]               ren_d;
    logic                     unused_addr_bits;

    assign unused_addr_bits = ^inst_addr[1:0];
    assign tag_l       = addr_q[31 -: TW];
    assign idx_l       = addr_q[OFF +: IW];
    assign word_l      = addr_q[2 +: OW];
    assign line_addr   = {addr_q[31:OFF], {OFF{1'b0}}};
    assign refill_word = dev_rdata[{word_l, 5'b0} +: 32];
    assign lookup      = (state_q == ST_LOOKUP);
    assign fill        = (state_q == ST_REFILL) && dev_rvalid;
    assign evict       = lookup && !hit && (&valid_q[idx_l]);

    always_comb begin
        hit      = 1'b0;
        hit_word = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[idx_l][WW'(w)] && tag_q[w][idx_l] == tag_l) begin
                hit      = 1'b1;
                hit_word = line_q[w][idx_l][{word_l, 5'b0} +: 32];
            end
        end
    end

    icache_victim_sel #(
        .WAYS      (WAYS),
        .SETS      (SETS),
        .REPL_MODE (REPL_MODE)
    ) u_victim (
        .clk       (cpu_clk),
        .rst_n     (cpu_rst_n),
        .valid_set (valid_q[idx_l]),
        .set_idx   (idx_l),
        .evict     (evict),
        .victim    (victim)
    );

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q    <= ST_IDLE;
            inst_valid <= 1'b0;
            inst_out   <= '0;
            inv_done   <= 1'b0;
            cpu_ren    <= '0;
            cpu_raddr  <= '0;
        end else begin
            state_q    <= state_d;
            inst_valid <= valid_d;
            inst_out   <= out_d;
            inv_done   <= done_d;
            cpu_ren    <= ren_d;
            cpu_raddr  <= raddr_d;
        end
    end

    // A miss seeing dev_rrdy already high skips MISS_WAIT so the registered
    // read enable lands two cycles after the request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (inv_req) state_d = ST_INVAL;
                          else if (inst_rreq) state_d = ST_LOOKUP;
            ST_LOOKUP:    if (hit) state_d = ST_IDLE;
                          else if (dev_rrdy) state_d = ST_REFILL;
                          else state_d = ST_MISS_WAIT;
            ST_MISS_WAIT: if (dev_rrdy) state_d = ST_REFILL;
            ST_REFILL:    if (dev_rvalid) state_d = ST_IDLE;
            ST_INVAL:     state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        valid_d = 1'b0;
        out_d   = inst_out;
        ren_d   = '0;
        raddr_d = '0;
        done_d  = 1'b0;
        case (state_q)
            ST_LOOKUP: begin
                if (hit) begin
                    valid_d = 1'b1;
                    out_d   = hit_word;
                end else if (dev_rrdy) begin
                    ren_d   = REN_LINE;
                    raddr_d = line_addr;
                end
            end
            ST_MISS_WAIT: begin
                if (dev_rrdy) begin
                    ren_d   = REN_LINE;
                    raddr_d = line_addr;
                end
            end
            ST_REFILL: begin
                if (dev_rvalid) begin
                    valid_d = 1'b1;
                    out_d   = refill_word;
                end
            end
            ST_INVAL: done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            addr_q   <= '0;
            victim_q <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
            for (int unsigned s = 0; s < SETS; s++) valid_q[s] <= '0;
        end else begin
            if (state_q == ST_IDLE && !inv_req && inst_rreq) addr_q <= inst_addr[31:2];
            if (lookup && hit && hit_cnt != '1) hit_cnt <= hit_cnt + 1;
            if (lookup && !hit) begin
                victim_q <= victim;
                if (miss_cnt != '1) miss_cnt <= miss_cnt + 1;
            end
            if (fill) valid_q[idx_l][victim_q] <= 1'b1;
            if (state_q == ST_INVAL) begin
                for (int unsigned s = 0; s < SETS; s++) valid_q[s] <= '0;
            end
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (fill) begin
            line_q[victim_q][idx_l] <= dev_rdata;
            tag_q[victim_q][idx_l]  <= tag_l;
        end
    end

endmodule
